// File: rtl/hazard_detect_unit.sv
// Decode-to-execute hazard tracker: forwarding code TypeE, load-use / store-data stalls, branch flushes.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_detect_unit #(
  parameter int REG_AW = 5
`ifdef HAZARD_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InstrValidD,
  input  logic [1:0]        OpClassD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] WriteRegD,
  input  logic              BranchTakenE,
  output logic [5:0]        TypeE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] StallCnt,
  output logic [STAT_W-1:0] FwdCnt,
  output logic [STAT_W-1:0] FlushCnt
`endif
);

  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic [REG_AW-1:0] dest;
  } rec_t;

  rec_t ex_rec_q, ex_rec_d, mem_rec_q, dec_rec;
  logic [5:0] type_q, type_d;

  logic              is_r, rt_no_fwd;
  logic              load_use, rt_block, hazard_stall;
  logic [REG_AW-1:0] src [2];
  logic [1:0]        d1_hit, d2_hit, src_load;
  logic [1:0]        src_dist [2];

  assign src[0]    = RsD;
  assign src[1]    = RtD;
  assign is_r      = (OpClassD == OP_R);
  assign rt_no_fwd = (OpClassD == OP_SW) || (OpClassD == OP_BEQ);

  // A valid record always has a nonzero dest, so a match implies a nonzero source.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign d1_hit[gi]   = ex_rec_q.valid && (src[gi] == ex_rec_q.dest);
      assign d2_hit[gi]   = mem_rec_q.valid && (src[gi] == mem_rec_q.dest);
      assign src_dist[gi] = d1_hit[gi] ? 2'b01 : (d2_hit[gi] ? 2'b10 : 2'b00);
      assign src_load[gi] = d1_hit[gi] ? ex_rec_q.is_load : (d2_hit[gi] && mem_rec_q.is_load);
    end
  endgenerate

  assign load_use = InstrValidD &&
                    ((d1_hit[0] && ex_rec_q.is_load) || (is_r && d1_hit[1] && ex_rec_q.is_load));
  assign rt_block = InstrValidD && rt_no_fwd && (d1_hit[1] || d2_hit[1]);
  assign hazard_stall = load_use || rt_block;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (hazard_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    dec_rec.valid   = InstrValidD && (is_r || (OpClassD == OP_LW)) && (WriteRegD != '0);
    dec_rec.is_load = (OpClassD == OP_LW);
    dec_rec.dest    = WriteRegD;
    ex_rec_d        = FlushE ? '0 : dec_rec;
    type_d          = 6'b000000;
    if (!FlushE && InstrValidD) begin
      type_d = {src_load[0], is_r && src_load[1], src_dist[0], is_r ? src_dist[1] : 2'b11};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_rec_q  <= '0;
      mem_rec_q <= '0;
      type_q    <= '0;
    end else begin
      ex_rec_q  <= ex_rec_d;
      mem_rec_q <= ex_rec_q;
      type_q    <= type_d;
    end
  end

  assign TypeE = type_q;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, fwd_cnt_q, flush_cnt_q;

  // Saturating counters: stop at all-ones rather than wrap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallD && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((type_d != 6'b000000) && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + 1'b1;
      if (BranchTakenE && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FwdCnt   = fwd_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench for hazard_detect_unit: directed vector table, hand-written
// reset/stats sequences, and randomized instruction streams against a history model.
module tb_hazard_detect_unit;

  logic       Clk;
  logic       Reset;
  logic       InstrValidD;
  logic [1:0] OpClassD;
  logic [4:0] RsD, RtD, WriteRegD;
  logic       BranchTakenE;
  logic [5:0] TypeE;
  logic       StallF, StallD, FlushD, FlushE;
`ifdef HAZARD_STATS_EN
  logic [15:0] StallCnt, FwdCnt, FlushCnt;
`endif

  hazard_detect_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .InstrValidD  (InstrValidD),
    .OpClassD     (OpClassD),
    .RsD          (RsD),
    .RtD          (RtD),
    .WriteRegD    (WriteRegD),
    .BranchTakenE (BranchTakenE),
    .TypeE        (TypeE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE)
`ifdef HAZARD_STATS_EN
    ,
    .StallCnt     (StallCnt),
    .FwdCnt       (FwdCnt),
    .FlushCnt     (FlushCnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a posedge: apply inputs, check combinational outputs mid-cycle,
  // then check the registered TypeE after the following edge.
  task automatic run_cycle(input string name, input logic v, input logic [1:0] op,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                           input logic br, input logic [3:0] exp_ctl, input logic [5:0] exp_t);
    InstrValidD = v; OpClassD = op; RsD = rs; RtD = rt; WriteRegD = wr; BranchTakenE = br;
    #4;
    check({name, " ctl"}, {28'd0, StallF, StallD, FlushD, FlushE}, {28'd0, exp_ctl});
    @(posedge Clk); #1;
    check({name, " TypeE"}, {26'd0, TypeE}, {26'd0, exp_t});
    $display("txn %s v=%0b op=%0d rs=%0d rt=%0d wr=%0d br=%0b ctl=%b TypeE=%b",
             name, v, op, rs, rt, wr, br, {StallF, StallD, FlushD, FlushE}, TypeE);
  endtask

  task automatic do_reset();
    Reset = 1'b1; InstrValidD = 1'b0; BranchTakenE = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [4:0] rs, rt, wr;
    logic       br;
    logic [3:0] ctl;   // {StallF, StallD, FlushD, FlushE}
    logic [5:0] t;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic v, input logic [1:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] wr, input logic br,
                         input logic [3:0] ctl, input logic [5:0] t);
    vec_t e;
    e.v = v; e.op = op; e.rs = rs; e.rt = rt; e.wr = wr; e.br = br; e.ctl = ctl; e.t = t;
    vecs.push_back(e);
  endtask

  // Reference model: history of what entered EX (index 0) and MEM (index 1).
  typedef struct {
    bit w;
    bit ld;
    int dest;
  } prod_t;

  prod_t pipe [2];

  function automatic int dist_of(input int src);
    for (int k = 0; k < 2; k++)
      if (pipe[k].w && src != 0 && pipe[k].dest == src) return k + 1;
    return 0;
  endfunction

  initial begin
    bit         m_stall;
    logic       rv, rbr, rrst;
    logic [1:0] rop;
    logic [4:0] rrs, rrt, rwr;

    Reset = 1'b1; InstrValidD = 1'b0; OpClassD = 2'b00;
    RsD = '0; RtD = '0; WriteRegD = '0; BranchTakenE = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset TypeE", {26'd0, TypeE}, 32'd0);
    #3;
    check("reset ctl", {28'd0, StallF, StallD, FlushD, FlushE}, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // op: 0 R, 1 LW, 2 SW, 3 BEQ
    add_vec(1, 0, 1, 2, 3, 0, 4'b0000, 6'b000000); // add $3,$1,$2
    add_vec(1, 0, 3, 4, 5, 0, 4'b0000, 6'b000100); // sub $5,$3,$4
    add_vec(0, 0, 0, 0, 0, 0, 4'b0000, 6'b000000); // nop
    add_vec(1, 0, 1, 2, 3, 0, 4'b0000, 6'b000000); // add $3,$1,$2
    add_vec(0, 0, 0, 0, 0, 0, 4'b0000, 6'b000000); // nop
    add_vec(1, 0, 4, 3, 6, 0, 4'b0000, 6'b000010); // or $6,$4,$3
    add_vec(1, 1, 1, 3, 3, 0, 4'b0000, 6'b000011); // lw $3,0($1)
    add_vec(1, 0, 2, 3, 5, 0, 4'b1101, 6'b000000); // add $5,$2,$3 load-use stall
    add_vec(1, 0, 2, 3, 5, 0, 4'b0000, 6'b010010); // add resolves at d2
    add_vec(1, 0, 1, 2, 3, 0, 4'b0000, 6'b000000); // add $3,$1,$2
    add_vec(1, 3, 3, 0, 0, 0, 4'b0000, 6'b000111); // beq $3,$0
    add_vec(1, 0, 1, 2, 3, 0, 4'b0000, 6'b000000); // add $3,$1,$2
    add_vec(1, 3, 0, 3, 0, 0, 4'b1101, 6'b000000); // beq $0,$3 stall d1
    add_vec(1, 3, 0, 3, 0, 0, 4'b1101, 6'b000000); // beq $0,$3 stall d2
    add_vec(1, 3, 0, 3, 0, 0, 4'b0000, 6'b000011); // beq $0,$3 proceeds
    add_vec(1, 0, 1, 2, 0, 0, 4'b0000, 6'b000000); // add $0,$1,$2
    add_vec(1, 0, 0, 0, 5, 0, 4'b0000, 6'b000000); // reads $0 only
    add_vec(1, 1, 1, 7, 7, 0, 4'b0000, 6'b000011); // lw $7,0($1)
    add_vec(1, 0, 7, 7, 8, 1, 4'b0011, 6'b000000); // load-use + branch: branch wins
    add_vec(1, 0, 7, 7, 8, 0, 4'b0000, 6'b111010); // add $8,$7,$7 both at d2 from load
    add_vec(1, 2, 8, 7, 7, 0, 4'b0000, 6'b000111); // sw $7,4($8)
    add_vec(1, 0, 7, 1, 9, 0, 4'b0000, 6'b000000); // sw's rt is not a destination

    foreach (vecs[i])
      run_cycle($sformatf("vec%0d", i), vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt,
                vecs[i].wr, vecs[i].br, vecs[i].ctl, vecs[i].t);

    // Load-use with statistics, then reset asserted in the middle of a stall.
    do_reset();
    run_cycle("seq lw", 1, 1, 1, 3, 3, 0, 4'b0000, 6'b000011);
    run_cycle("seq stall", 1, 0, 2, 3, 5, 0, 4'b1101, 6'b000000);
    run_cycle("seq resolve", 1, 0, 2, 3, 5, 0, 4'b0000, 6'b010010);
`ifdef HAZARD_STATS_EN
    check("stats StallCnt", {16'd0, StallCnt}, 32'd1);
`endif
    run_cycle("seq lw2", 1, 1, 1, 3, 3, 0, 4'b0000, 6'b000011);
    InstrValidD = 1'b1; OpClassD = 2'b00; RsD = 5'd2; RtD = 5'd3; WriteRegD = 5'd5;
    #4;
    check("midreset stall", {28'd0, StallF, StallD, FlushD, FlushE}, 32'b1101);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("midreset TypeE", {26'd0, TypeE}, 32'd0);
    #3;
    check("midreset ctl", {28'd0, StallF, StallD, FlushD, FlushE}, 32'd0);
    @(posedge Clk); #1;

    // Randomized streams over a small register set so hazards are frequent.
    do_reset();
    pipe[0] = '{0, 0, 0}; pipe[1] = '{0, 0, 0};
    m_stall = 0;
    rv = 0; rop = 0; rrs = 0; rrt = 0; rwr = 0;
    for (int n = 0; n < 1500; n++) begin
      int  da, db;
      bit  lda, ldb, is_r, lu, rtb, fe;
      logic [3:0] ectl;
      logic [5:0] et;
      prod_t np;
      rrst = ($urandom_range(0, 49) == 0);
      if (!m_stall) begin
        rv  = ($urandom_range(0, 7) != 0);
        rop = 2'($urandom_range(0, 3));
        rrs = 5'($urandom_range(0, 3));
        rrt = 5'($urandom_range(0, 3));
        rwr = 5'($urandom_range(0, 3));
      end
      rbr = ($urandom_range(0, 9) == 0);
      is_r = (rop == 0);
      da = dist_of(int'(rrs));
      db = dist_of(int'(rrt));
      lda = (da != 0) && pipe[da-1].ld;
      ldb = (db != 0) && pipe[db-1].ld;
      lu  = rv && ((da == 1 && lda) || (is_r && db == 1 && ldb));
      rtb = rv && (rop == 2 || rop == 3) && (db != 0);
      if (rbr)            ectl = 4'b0011;
      else if (lu || rtb) ectl = 4'b1101;
      else                ectl = 4'b0000;
      fe = ectl[0];
      if (rrst || fe || !rv) et = 6'd0;
      else et = 6'((int'(lda) << 5) + (int'(is_r && ldb) << 4) + (da << 2) + (is_r ? db : 3));

      Reset = rrst;
      run_cycle($sformatf("rnd%0d", n), rv, rop, rrs, rrt, rwr, rbr, ectl, et);
      Reset = 1'b0;

      np.w = rv && (rop == 0 || rop == 1) && (rwr != 0) && !fe;
      np.ld = (rop == 1);
      np.dest = int'(rwr);
      if (rrst) begin
        pipe[0] = '{0, 0, 0}; pipe[1] = '{0, 0, 0};
      end else begin
        pipe[1] = pipe[0];
        pipe[0] = np;
      end
      m_stall = ectl[2] && !rrst;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
